// File: rtl/pulse_avg_pkg.sv
// Shared state encoding and sample/accumulator helpers for the pulse averager.
package pulse_avg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_READOUT = 2'd3
  } state_e;

  function automatic logic [63:0] sext16(input logic [15:0] x);
    return {{48{x[15]}}, x};
  endfunction

  // Arithmetic right shift of a sign-extended accumulator, keeping the low 16 bits.
  function automatic logic [15:0] shr16(input logic signed [63:0] a, input logic [4:0] sh);
    return 16'(a >>> sh);
  endfunction

endpackage

// File: rtl/pulse_avg_ctrl_if.sv
// Input and output sample streams of the pulse averager; master is the averager side.
interface pulse_avg_ctrl_if;
  logic [31:0]  i_tdata;
  logic [127:0] i_tuser;
  logic         i_tvalid;
  logic         i_tlast;
  logic         i_tready;
  logic [31:0]  o_tdata;
  logic [127:0] o_tuser;
  logic         o_tvalid;
  logic         o_tlast;
  logic         o_tready;

  modport master (
    input  i_tdata, i_tuser, i_tvalid, i_tlast,
    output i_tready,
    output o_tdata, o_tuser, o_tvalid, o_tlast,
    input  o_tready
  );

  modport slave (
    output i_tdata, i_tuser, i_tvalid, i_tlast,
    input  i_tready,
    input  o_tdata, o_tuser, o_tvalid, o_tlast,
    output o_tready
  );
endinterface

// File: rtl/pulse_avg_obuf.sv
// Two-entry output buffer between memory readout and the output stream.
// Head entry is presented combinationally; storage resets to zero.
module pulse_avg_obuf #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic         vld_o,
  output logic [W-1:0] dat_o,
  output logic [1:0]   cnt_o
);
  logic [W-1:0] mem_q [2];
  logic         wp_q, rp_q;
  logic [1:0]   cnt_q;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wp_q] <= push_dat_i;
        wp_q        <= ~wp_q;
      end
      if (pop_i) rp_q <= ~rp_q;
      cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign vld_o = (cnt_q != 2'd0);
  assign dat_o = mem_q[rp_q];
  assign cnt_o = cnt_q;
endmodule

// File: rtl/pulse_avg_ctrl.sv
// Pulse averager: sums num_avg pulses of I/Q samples in external memory (1-cycle read),
// then streams the shifted sums out; input stalls outside ACCUM, output holds until o_tready.
module pulse_avg_ctrl
  import pulse_avg_pkg::*;
#(
  parameter int MAX_PULSE_SIZE = 8192,
  parameter int ACC_WIDTH      = 24
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              clear,
  input  logic [31:0]                       pulse_size,
  input  logic [31:0]                       num_avg,
  input  logic [4:0]                        avg_shift,
  output logic [31:0]                       num_count,
  pulse_avg_ctrl_if.master                  axis,
  output logic [$clog2(MAX_PULSE_SIZE)-1:0] mem_rd_addr,
  output logic                              mem_rd_ena,
  input  logic [2*ACC_WIDTH-1:0]            mem_rd_data,
  output logic [$clog2(MAX_PULSE_SIZE)-1:0] mem_wr_addr,
  output logic [2*ACC_WIDTH-1:0]            mem_wr_data,
  output logic                              mem_wr_ena
);
  localparam int AW = $clog2(MAX_PULSE_SIZE);
  localparam int CW = AW + 1;

  logic rst;
  assign rst = reset | clear;

  state_e                 state_q, state_d;
  logic [CW-1:0]          psize_q, psize_d, rd_cnt_q, rd_cnt_d;
  logic [31:0]            navg_q, navg_d, cnt_q, cnt_d, smp_q, smp_d;
  logic [4:0]             shift_q, shift_d;
  logic [AW-1:0]          pos_q, pos_d, wr_addr_q, wr_addr_d;
  logic                   wr_ena_q, wr_ena_d, first_q, first_d, fwd_q, fwd_d;
  logic                   infl_q, infl_d, infl_last_q, infl_last_d;
  logic [2*ACC_WIDTH-1:0] fwd_dat_q, fwd_dat_d;
  logic [127:0]           tuser_q, tuser_d;

  logic                        accept, issue, pos_last, pulse_last;
  logic                        ob_pop, ob_vld, ob_last;
  logic [1:0]                  ob_cnt;
  logic [31:0]                 ob_dat, push_dat;
  logic [2*ACC_WIDTH-1:0]      base;
  logic [ACC_WIDTH-1:0]        sum_re, sum_im;
  logic signed [ACC_WIDTH-1:0] rd_re, rd_im;
  logic                        unused_tlast;

  assign unused_tlast = axis.i_tlast;

  assign accept     = (state_q == ST_ACCUM) && axis.i_tvalid;
  assign pos_last   = (CW'(pos_q) == psize_q - CW'(1));
  assign pulse_last = (cnt_q == navg_q - 32'd1);
  assign issue      = (state_q == ST_READOUT) && (rd_cnt_q != psize_q) &&
                      ((ob_cnt + {1'b0, infl_q}) < 2'd2);

  // With a one-sample pulse the previous write lands on the address being read.
  assign base   = fwd_q ? fwd_dat_q : mem_rd_data;
  assign sum_re = ACC_WIDTH'(sext16(smp_q[31:16])) +
                  (first_q ? '0 : base[2*ACC_WIDTH-1:ACC_WIDTH]);
  assign sum_im = ACC_WIDTH'(sext16(smp_q[15:0])) +
                  (first_q ? '0 : base[ACC_WIDTH-1:0]);

  assign rd_re    = mem_rd_data[2*ACC_WIDTH-1:ACC_WIDTH];
  assign rd_im    = mem_rd_data[ACC_WIDTH-1:0];
  assign push_dat = {shr16(64'(rd_re), shift_q), shr16(64'(rd_im), shift_q)};

  always_comb begin
    state_d     = state_q;
    psize_d     = psize_q;
    navg_d      = navg_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    pos_d       = pos_q;
    rd_cnt_d    = rd_cnt_q;
    tuser_d     = tuser_q;
    wr_ena_d    = accept;
    wr_addr_d   = pos_q;
    smp_d       = axis.i_tdata;
    first_d     = (cnt_q == 32'd0);
    fwd_d       = accept && wr_ena_q && (pos_q == wr_addr_q);
    fwd_dat_d   = mem_wr_data;
    infl_d      = issue;
    infl_last_d = issue && (rd_cnt_q == psize_q - CW'(1));
    unique case (state_q)
      ST_IDLE: begin
        if (pulse_size == 32'd0)                       psize_d = CW'(1);
        else if (pulse_size > 32'(MAX_PULSE_SIZE))     psize_d = CW'(MAX_PULSE_SIZE);
        else                                           psize_d = CW'(pulse_size);
        navg_d   = (num_avg == 32'd0) ? 32'd1 : num_avg;
        shift_d  = avg_shift;
        cnt_d    = '0;
        pos_d    = '0;
        rd_cnt_d = '0;
        state_d  = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (accept) begin
          if ((pos_q == '0) && pulse_last) tuser_d = axis.i_tuser;
          if (pos_last) begin
            pos_d = '0;
            cnt_d = cnt_q + 32'd1;
            if (pulse_last) state_d = ST_FLUSH;
          end else begin
            pos_d = pos_q + 1'b1;
          end
        end
      end
      ST_FLUSH: state_d = ST_READOUT;
      ST_READOUT: begin
        if (issue) rd_cnt_d = rd_cnt_q + 1'b1;
        if (ob_pop && ob_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      psize_q     <= '0;
      navg_q      <= '0;
      shift_q     <= '0;
      cnt_q       <= '0;
      pos_q       <= '0;
      rd_cnt_q    <= '0;
      tuser_q     <= '0;
      wr_ena_q    <= 1'b0;
      wr_addr_q   <= '0;
      smp_q       <= '0;
      first_q     <= 1'b0;
      fwd_q       <= 1'b0;
      fwd_dat_q   <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      psize_q     <= psize_d;
      navg_q      <= navg_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      pos_q       <= pos_d;
      rd_cnt_q    <= rd_cnt_d;
      tuser_q     <= tuser_d;
      wr_ena_q    <= wr_ena_d;
      wr_addr_q   <= wr_addr_d;
      smp_q       <= smp_d;
      first_q     <= first_d;
      fwd_q       <= fwd_d;
      fwd_dat_q   <= fwd_dat_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
    end
  end

  pulse_avg_obuf #(.W(33)) u_obuf (
    .clk        (clk),
    .rst_i      (rst),
    .push_i     (infl_q),
    .push_dat_i ({infl_last_q, push_dat}),
    .pop_i      (ob_pop),
    .vld_o      (ob_vld),
    .dat_o      ({ob_last, ob_dat}),
    .cnt_o      (ob_cnt)
  );

  assign ob_pop        = axis.o_tvalid && axis.o_tready;
  assign axis.o_tvalid = ob_vld && (state_q == ST_READOUT);
  assign axis.o_tlast  = axis.o_tvalid && ob_last;
  assign axis.o_tdata  = ob_dat;
  assign axis.o_tuser  = tuser_q;
  assign axis.i_tready = (state_q == ST_ACCUM);

  assign num_count   = cnt_q;
  assign mem_rd_ena  = accept | issue;
  assign mem_rd_addr = (state_q == ST_READOUT) ? rd_cnt_q[AW-1:0] : pos_q;
  assign mem_wr_ena  = wr_ena_q;
  assign mem_wr_addr = wr_addr_q;
  assign mem_wr_data = {sum_re, sum_im};
endmodule

// File: tb/tb_pulse_avg_ctrl.sv
// Directed bench for pulse_avg_ctrl with a read-before-write, 1-cycle-latency memory model.
module tb_pulse_avg_ctrl;
  localparam int MAXP = 8192;
  localparam int AW   = 13;
  localparam int ACC  = 24;

  logic            clk = 1'b0;
  logic            reset, clear;
  logic [31:0]     pulse_size, num_avg, num_count;
  logic [4:0]      avg_shift;
  logic [AW-1:0]   mem_rd_addr, mem_wr_addr;
  logic            mem_rd_ena, mem_wr_ena;
  logic [2*ACC-1:0] mem_rd_data, mem_wr_data;
  logic [2*ACC-1:0] mem [MAXP];

  int checks   = 0;
  int failures = 0;
  logic [31:0] beat_dat [$];
  logic        beat_last [$];
  logic [31:0] exp_q [$];

  pulse_avg_ctrl_if ifc();

  always #5 clk = ~clk;

  pulse_avg_ctrl #(.MAX_PULSE_SIZE(MAXP), .ACC_WIDTH(ACC)) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .pulse_size  (pulse_size),
    .num_avg     (num_avg),
    .avg_shift   (avg_shift),
    .num_count   (num_count),
    .axis        (ifc),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_ena  (mem_rd_ena),
    .mem_rd_data (mem_rd_data),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .mem_wr_ena  (mem_wr_ena)
  );

  always @(posedge clk) begin
    if (mem_rd_ena) mem_rd_data <= mem[mem_rd_addr];
    if (mem_wr_ena) mem[mem_wr_addr] <= mem_wr_data;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] i, input logic [15:0] q, input logic [127:0] user);
    int n = 0;
    ifc.i_tdata  = {i, q};
    ifc.i_tuser  = user;
    ifc.i_tlast  = i[0];
    ifc.i_tvalid = 1'b1;
    while (!ifc.i_tready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_ready", 128'(ifc.i_tready), 128'd1);
    @(negedge clk);
  endtask

  task automatic start_run(input int ps, input int na, input int sh);
    pulse_size = 32'(ps);
    num_avg    = 32'(na);
    avg_shift  = 5'(sh);
    clear      = 1'b1;
    @(negedge clk);
    clear      = 1'b0;
  endtask

  task automatic collect(input bit toggle);
    int cyc  = 0;
    bit rdy  = 1'b1;
    bit done = 1'b0;
    beat_dat.delete();
    beat_last.delete();
    while (!done && cyc < 500) begin
      ifc.o_tready = rdy;
      if (ifc.o_tvalid && rdy) begin
        beat_dat.push_back(ifc.o_tdata);
        beat_last.push_back(ifc.o_tlast);
        done = ifc.o_tlast;
      end
      @(negedge clk);
      cyc++;
      if (toggle) rdy = !rdy;
    end
    ifc.o_tready = 1'b0;
    chk("readout_done", 128'(done), 128'd1);
    chk("idle_after_last", 128'(ifc.o_tvalid), 128'd0);
  endtask

  task automatic chk_beats(input string tag);
    chk({tag, "_nbeats"}, 128'(beat_dat.size()), 128'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < beat_dat.size()) begin
        chk($sformatf("%s_dat%0d", tag, k), 128'(beat_dat[k]), 128'(exp_q[k]));
        chk($sformatf("%s_last%0d", tag, k), 128'(beat_last[k]),
            128'(k == exp_q.size() - 1));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; clear = 1'b0;
    pulse_size = '0; num_avg = '0; avg_shift = '0;
    ifc.i_tdata = '0; ifc.i_tuser = '0; ifc.i_tlast = 1'b0;
    ifc.i_tvalid = 1'b1; ifc.o_tready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_i_tready", 128'(ifc.i_tready), 128'd0);
    chk("rst_o_tvalid", 128'(ifc.o_tvalid), 128'd0);
    chk("rst_o_tlast", 128'(ifc.o_tlast), 128'd0);
    chk("rst_rd_ena", 128'(mem_rd_ena), 128'd0);
    chk("rst_wr_ena", 128'(mem_wr_ena), 128'd0);
    chk("rst_num_count", 128'(num_count), 128'd0);
    chk("rst_o_tdata", 128'(ifc.o_tdata), 128'd0);
    chk("rst_o_tuser", ifc.o_tuser, 128'd0);
    ifc.i_tvalid = 1'b0;
    reset = 1'b0;

    // 4-sample pulses averaged 3 times; config is disturbed mid-run.
    start_run(4, 3, 0);
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 4; k++) begin
        send(16'(k + 1), 16'(k + 1), 128'(100 * p + k));
        if (p == 0 && k == 0) begin
          pulse_size = 32'd7; num_avg = 32'd9; avg_shift = 5'd3;
        end
        if (p == 0 && k == 3) chk("t1_count_p0", 128'(num_count), 128'd1);
      end
    end
    ifc.i_tvalid = 1'b0;
    chk("t1_count_end", 128'(num_count), 128'd3);
    chk("t1_tuser", ifc.o_tuser, 128'd200);
    exp_q = '{32'h0003_0003, 32'h0006_0006, 32'h0009_0009, 32'h000C_000C};
    collect(1'b0);
    chk_beats("t1");

    // Single-sample pulses, back-to-back: relies on write forwarding.
    start_run(1, 4, 2);
    repeat (4) send(16'hFFFE, 16'h0005, 128'd0);
    ifc.i_tvalid = 1'b0;
    chk("t2_count", 128'(num_count), 128'd4);
    exp_q = '{32'hFFFE_0005};
    collect(1'b0);
    chk_beats("t2");

    // 8-sample pulses, output ready toggling every cycle.
    start_run(8, 2, 0);
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 8; k++)
        send(16'(k + 1), 16'(16'hFFF0 + p), 128'd0);
    ifc.i_tvalid = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 8; k++) exp_q.push_back({16'(2 * k + 2), 16'hFFE1});
    collect(1'b1);
    chk_beats("t3");

    // Zero sizes clamp to one sample, one pulse.
    start_run(0, 0, 0);
    send(16'h1234, 16'hFEDC, 128'd0);
    ifc.i_tvalid = 1'b0;
    chk("t4_count", 128'(num_count), 128'd1);
    exp_q = '{32'h1234_FEDC};
    collect(1'b0);
    chk_beats("t4");

    // Clear during the second pulse, then a fresh run.
    start_run(8, 2, 0);
    repeat (13) send(16'h0100, 16'h0100, 128'd0);
    pulse_size = 32'd4; num_avg = 32'd2; avg_shift = 5'd1;
    ifc.i_tvalid = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("t5_tready_after_clear", 128'(ifc.i_tready), 128'd0);
    chk("t5_wr_after_clear", 128'(mem_wr_ena), 128'd0);
    chk("t5_count_after_clear", 128'(num_count), 128'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("t5_no_wr%0d", c), 128'(mem_wr_ena), 128'd0);
    end
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 4; k++)
        send(16'(4 * (k + 1)), 16'hFFFE, 128'd0);
    ifc.i_tvalid = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back({16'(4 * (k + 1)), 16'hFFFE});
    collect(1'b0);
    chk_beats("t5");

    // Full-scale accumulation over 256 pulses.
    start_run(1, 256, 8);
    repeat (256) send(16'h7FFF, 16'h8000, 128'd0);
    ifc.i_tvalid = 1'b0;
    chk("t6_count", 128'(num_count), 128'd256);
    exp_q = '{32'h7FFF_8000};
    collect(1'b0);
    chk_beats("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pulse_avg_ctrl.md
PULSE_AVG_CTRL -- requirements
Module: pulse_avg_ctrl

Interface
REQ-001 SHALL have parameter MAX_PULSE_SIZE, default 8192: pulse-memory depth in samples; must be a power of two.
REQ-002 SHALL have parameter ACC_WIDTH, default 24: accumulator width per I/Q component.
REQ-003 SHALL have ports: clk in 1, the single clock; reset in 1, synchronous, active-high; clear in 1, synchronous soft reset.
REQ-004 SHALL have config ports: pulse_size in 32; num_avg in 32; avg_shift in 5, output right-shift; num_count out 32, completed pulses.
REQ-005 SHALL have input stream ports: i_tdata in 32 ({I[31:16],Q[15:0]}, signed); i_tuser in 128; i_tvalid in 1; i_tlast in 1; i_tready out 1.
REQ-006 SHALL have output stream ports: o_tdata out 32; o_tuser out 128; o_tvalid out 1; o_tlast out 1; o_tready in 1.
REQ-007 SHALL have memory ports: mem_rd_addr out log2(MAX_PULSE_SIZE); mem_rd_ena out 1; mem_rd_data in 2*ACC_WIDTH; mem_wr_addr out log2(MAX_PULSE_SIZE); mem_wr_data out 2*ACC_WIDTH; mem_wr_ena out 1. Memory read latency is exactly 1 cycle.

Function
REQ-008 SHALL implement states IDLE, ACCUM, FLUSH, READOUT.
REQ-009 IDLE SHALL latch config and go to ACCUM next cycle: pulse_size 0 -> 1, >MAX_PULSE_SIZE -> MAX_PULSE_SIZE; num_avg 0 -> 1.
REQ-010 i_tready SHALL be high only in ACCUM; a sample is accepted on i_tvalid & i_tready.
REQ-011 For each accepted sample at position pos, SHALL assert mem_rd_ena with mem_rd_addr=pos that cycle, then mem_wr_ena with mem_wr_addr=pos the following cycle.
REQ-012 Write data SHALL be the sign-extended sample for pulse 0, else mem_rd_data + sign-extended sample per component, wrapping modulo 2^ACC_WIDTH.
REQ-013 If a read address equals the address being written the same cycle (pulse_size=1 back-to-back), SHALL forward mem_wr_data instead of mem_rd_data.
REQ-014 pos SHALL wrap to 0 after pulse_size-1; each wrap SHALL increment num_count; pulse boundaries depend only on the count, and i_tlast SHALL be ignored.
REQ-015 On the first sample of the final pulse, SHALL capture i_tuser for o_tuser.
REQ-016 After the last sample of pulse num_avg-1, SHALL enter FLUSH for one cycle to retire the pending write, then READOUT.
REQ-017 READOUT SHALL read addresses 0..pulse_size-1 in order into a 2-entry output buffer; a read SHALL issue only when buffer occupancy plus in-flight reads < 2.
REQ-018 o_tdata SHALL be {I_acc>>>avg_shift, Q_acc>>>avg_shift}, arithmetic shift, truncated to 16 bits each.
REQ-019 o_tlast SHALL assert with address pulse_size-1; o_tvalid is held until o_tready; on that final handshake SHALL return to IDLE.
REQ-020 num_count SHALL hold its final value through READOUT and reset to 0 on entering ACCUM.
REQ-021 clear SHALL act identically to reset; memory contents need not be cleared, because pulse 0 overwrites them.
REQ-022 Config changes outside IDLE SHALL have no effect until the next run.

Reset
REQ-023 On reset: state=IDLE, i_tready=0, o_tvalid=0, o_tlast=0, mem_rd_ena=0, mem_wr_ena=0, num_count=0, pos=0, output buffer empty, o_tdata/o_tuser=0.
REQ-024 Reset or clear mid-ACCUM or mid-READOUT SHALL abort in the next cycle with no further memory write or output beat.

Structure
REQ-025 State encodings and the sign-extend/shift helper functions SHALL reside in a shared package, pulse_avg_pkg.
REQ-026 The 2-entry output buffer SHALL be one sub-module, pulse_avg_obuf; the pulse memory SHALL be external.

Verification
REQ-027 pulse_size=4, num_avg=3, inputs {1,1},{2,2},{3,3},{4,4} each pulse, avg_shift=0 -> outputs {3,3},{6,6},{9,9},{12,12}, tlast on beat 4, num_count=3.
REQ-028 pulse_size=1, num_avg=4, i_tvalid continuous with value {-2,5}, avg_shift=2 -> one beat {-2,5}, tlast=1, proving forwarding.
REQ-029 pulse_size=8, num_avg=2, o_tready toggling 1010... -> 8 beats, none dropped or duplicated, tlast on beat 8.
REQ-030 num_avg=0, pulse_size=0 -> treated as 1/1; single input beat echoed once.
REQ-031 Assert clear after 5 samples of pulse 1 -> i_tready=0 next cycle, no mem_wr_ena after it; new run gives correct sums.
REQ-032 I={0x7FFF} for 256 pulses, ACC_WIDTH=24, avg_shift=8 -> output I=0x7FFF.
